// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants, opcode encodings and fetch state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem request/response bus plus decode-side fetch handshake
interface instr_fetch_unit_if;
  import riscv_pkg::*;
  logic            PCSrc;
  logic [XLEN-1:0] ImmExt;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     Instr;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic            fetch_fault;
  modport master (
    input  PCSrc, ImmExt, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_addr, instr_valid, Instr, PC, PCPlus4, fetch_fault
  );
  modport slave (
    output PCSrc, ImmExt, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_addr, instr_valid, Instr, PC, PCPlus4, fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit_pc_next_gen.sv
// pc_next_gen: combinational next-PC select (PC+4 or PC+ImmExt) with misalignment flag
module pc_next_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic            PCSrc,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCNext,
  output logic            misalign
);
  assign PCPlus4  = pc + XLEN'(4);
  assign PCNext   = PCSrc ? pc + ImmExt : PCPlus4;
  assign misalign = |PCNext[1:0];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, one-outstanding imem fetch FSM; FETCH_BYPASS_EN forwards responses straight to decode
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, pc_next;
  logic [31:0]     instr_q, instr_d;
  logic            fault_q, fault_d, misalign, bypass, retire;
  pc_next_gen u_pc_next_gen (
    .pc(pc_q), .ImmExt(bus.ImmExt), .PCSrc(bus.PCSrc),
    .PCPlus4(pc_plus4), .PCNext(pc_next), .misalign(misalign)
  );
`ifdef FETCH_BYPASS_EN
  assign bypass = state_q == WAIT && bus.imem_rsp_valid;
`else
  assign bypass = 1'b0;
`endif
  assign retire = bus.instr_ready && (state_q == HOLD || bypass);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = bus.imem_req_ready ? WAIT : REQ;
      WAIT:    begin
        instr_d = bus.imem_rsp_valid ? bus.imem_rsp_data : instr_q;
        state_d = bus.imem_rsp_valid ? HOLD : WAIT;
      end
      default: state_d = state_q;
    endcase
    if (retire) begin
      state_d = misalign ? FAULT : REQ;
      pc_d    = misalign ? pc_q : pc_next;
      fault_d = fault_q | misalign;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end
  assign bus.imem_req_valid = state_q == REQ;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = state_q == HOLD || bypass;
  assign bus.Instr          = bypass ? bus.imem_rsp_data : instr_q;
  assign bus.PC             = pc_q;
  assign bus.PCPlus4        = pc_plus4;
  assign bus.fetch_fault    = fault_q;
endmodule
